// File: rtl/dvs_event_assembler.sv
// dvs_event_assembler: pairs eDVS serial bytes (1yyyyyyy, pxxxxxxx) into
// address events, buffers them in a small FIFO and presents them on a
// valid/ready interface. Counts framing errors and overflow drops.
// Optional build macro DVS_EVENT_ASM_TIMEOUT_EN adds a byte0->byte1 timeout.
module dvs_event_assembler #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_WIDTH    = 2,
    parameter int TIMEOUT_COUNT = 8680
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   byte_in,
    input  logic                    byte_strobe,
    output logic [2*DATA_WIDTH-2:0] event_data,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [7:0]              sync_errors,
    output logic [7:0]              overflow_drops,
    output logic [ADDR_WIDTH:0]     fifo_level
);

    localparam int YW = DATA_WIDTH - 1;
    localparam int EW = 2 * DATA_WIDTH - 1;

    // Elaboration-time parameter sanity checks.
    generate
        if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("FIFO_DEPTH must equal 2**ADDR_WIDTH");
        end
        if (TIMEOUT_COUNT < 2 || TIMEOUT_COUNT > (1 << 14)) begin : g_bad_timeout
            $error("TIMEOUT_COUNT must fit the 14-bit timer and be >= 2");
        end
    endgenerate

    typedef enum logic {WAIT_HI, WAIT_LO} state_t;

    state_t          state, state_nx;
    logic            strobe_d;
    logic            accept;
    logic            sync_bit;
    logic [YW-1:0]   y_q, y_nx;
    logic            push, err, timeout;
    logic            pop, full, do_write, drop;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

    // One accept per receiver byte: rising edge of the level strobe.
    assign accept   = byte_strobe & ~strobe_d;
    assign sync_bit = byte_in[DATA_WIDTH-1];

    // Strobe edge-detect register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) strobe_d <= 1'b0;
        else       strobe_d <= byte_strobe;
    end

`ifdef DVS_EVENT_ASM_TIMEOUT_EN
    logic [13:0] tmr;

    // Timer counts idle cycles in WAIT_LO; any accept restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            tmr <= '0;
        else if (accept || state != WAIT_LO)  tmr <= '0;
        else                                  tmr <= tmr + 14'd1;
    end

    // An accept on the same edge takes priority over the timeout.
    assign timeout = (state == WAIT_LO) && !accept && (tmr == 14'(TIMEOUT_COUNT - 1));
`else
    assign timeout = 1'b0;
`endif

    // FSM state and latched y register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_HI;
            y_q   <= '0;
        end else begin
            state <= state_nx;
            y_q   <= y_nx;
        end
    end

    // Next-state: byte pairing, resync and framing-error detection.
    always_comb begin
        state_nx = state;
        y_nx     = y_q;
        push     = 1'b0;
        err      = 1'b0;
        unique case (state)
            WAIT_HI: begin
                if (accept) begin
                    if (sync_bit) begin
                        y_nx     = byte_in[YW-1:0];
                        state_nx = WAIT_LO;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            WAIT_LO: begin
                if (accept) begin
                    if (sync_bit) begin
                        // Resync: a fresh byte0 replaces the stale one.
                        y_nx = byte_in[YW-1:0];
                        err  = 1'b1;
                    end else begin
                        push     = 1'b1;
                        state_nx = WAIT_HI;
                    end
                end else if (timeout) begin
                    err      = 1'b1;
                    state_nx = WAIT_HI;
                end
            end
            default: state_nx = WAIT_HI;
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when popped that cycle.
    assign event_valid = (fifo_level != '0);
    assign pop         = event_valid & event_ready;
    assign full        = (fifo_level == (ADDR_WIDTH+1)'(FIFO_DEPTH));
    assign do_write    = push & (~full | pop);
    assign drop        = push & full & ~pop;
    assign event_data  = mem[rd_ptr];

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= {y_q, byte_in[YW-1:0], sync_bit};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + (ADDR_WIDTH+1)'(do_write) - (ADDR_WIDTH+1)'(pop);
        end
    end

    // Saturating error and drop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_errors    <= '0;
            overflow_drops <= '0;
        end else begin
            if (err  && sync_errors    != 8'hFF) sync_errors    <= sync_errors + 8'd1;
            if (drop && overflow_drops != 8'hFF) overflow_drops <= overflow_drops + 8'd1;
        end
    end

endmodule

// File: tb/tb_dvs_event_assembler.sv
// tb_dvs_event_assembler: directed and randomized stimulus checked every cycle
// against a queue-based reference model of the event assembler.
module tb_dvs_event_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_strobe = 1'b0;
    logic [14:0] event_data;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [7:0]  sync_errors;
    logic [7:0]  overflow_drops;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [14:0] m_q[$];
    bit          m_lo;
    logic [6:0]  m_y;
    int          m_err, m_drop;
    bit          m_sd;

    dvs_event_assembler dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_strobe(byte_strobe),
        .event_data(event_data), .event_valid(event_valid), .event_ready(event_ready),
        .sync_errors(sync_errors), .overflow_drops(overflow_drops), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_lo = 0; m_y = '0; m_err = 0; m_drop = 0; m_sd = 0;
    endtask

    task automatic check_outputs();
        chk("level", fifo_level, m_q.size());
        chk("valid", event_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("data", event_data, m_q[0]);
        chk("sync_errors", sync_errors, m_err);
        chk("overflow_drops", overflow_drops, m_drop);
    endtask

    // One clock: drive inputs, advance the model by the spec rules, then check.
    task automatic cycle(input logic [7:0] b, input bit s, input bit rdy);
        bit acc, pop;
        byte_in = b; byte_strobe = s; event_ready = rdy;
        acc = s && !m_sd;
        pop = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            if (!m_lo) begin
                if (b[7]) begin m_y = b[6:0]; m_lo = 1; end
                else if (m_err < 255) m_err++;
            end else if (b[7]) begin
                m_y = b[6:0];
                if (m_err < 255) m_err++;
            end else begin
                m_lo = 0;
                if (m_q.size() < 4) m_q.push_back({m_y, b[6:0], b[7]});
                else if (m_drop < 255) m_drop++;
            end
        end
        m_sd = s;
        @(posedge clk); #1;
        check_outputs();
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 high only on the accept cycle.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap, input int rmode);
        for (int i = 0; i < hold + gap; i++) begin
            bit r;
            case (rmode)
                0: r = 0;
                1: r = 1;
                2: r = $urandom_range(1, 0) != 0;
                default: r = (i == 0);
            endcase
            cycle(b, i < hold, r);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(8'h00, 0, rdy);
    endtask

    task automatic mid_reset();
        byte_strobe = 0;
        #2 reset = 1;
        #1;
        chk("rst_valid", event_valid, 0);
        chk("rst_data", event_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_serr", sync_errors, 0);
        chk("rst_drops", overflow_drops, 0);
        model_clear();
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        logic [14:0] exp_ev;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("init_valid", event_valid, 0);
        chk("init_data", event_data, 0);
        chk("init_level", fifo_level, 0);
        chk("init_serr", sync_errors, 0);
        chk("init_drops", overflow_drops, 0);
        reset = 0;

        // Basic pair, strobe held 20 cycles per byte.
        send_byte(8'hA5, 20, 3, 0);
        cycle(8'h3C, 1, 0);
        chk("t1_valid_lat", event_valid, 1);
        exp_ev = {7'h25, 7'h3C, 1'b0};
        chk("t1_event", event_data, exp_ev);
        send_byte(8'h3C, 19, 2, 0);
        idle(3, 1);

        // Resync inside WAIT_LO.
        send_byte(8'h81, 4, 2, 0);
        send_byte(8'h82, 4, 2, 0);
        send_byte(8'h05, 4, 2, 0);
        exp_ev = {7'h02, 7'h05, 1'b0};
        chk("t3_event", event_data, exp_ev);
        idle(3, 1);

        // Stray low byte, then a resync with an all-ones byte, then a pair.
        send_byte(8'h12, 2, 2, 2);
        send_byte(8'h81, 2, 2, 2);
        send_byte(8'hFF, 2, 2, 2);
        send_byte(8'h05, 2, 2, 2);
        idle(4, 1);

        // Six pairs with ready low: four stored, two dropped, then drain.
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h80 | 8'(i), 2, 1, 0);
            send_byte(8'(i * 9 + 1) & 8'h7F, 2, 1, 0);
        end
        chk("t4_level", fifo_level, 4);
        idle(6, 1);

        // Full FIFO with a pop on the push edge.
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0 | 8'(i), 1, 1, 0);
            send_byte(8'h10 + 8'(i), 1, 1, 0);
        end
        send_byte(8'hAA, 1, 1, 0);
        send_byte(8'h55, 1, 1, 3);
        chk("t5_level", fifo_level, 4);
        idle(6, 1);

        // Randomized traffic, biased toward well-formed pairs.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(3, 0) != 0) b[7] = !m_lo;
            send_byte(b, $urandom_range(4, 1), $urandom_range(3, 1), 2);
        end
        idle(6, 1);

        // Reset in the middle of a half-assembled event.
        send_byte(8'h81, 3, 2, 0);
        mid_reset();
        send_byte(8'h05, 3, 2, 1);
        chk("post_rst_serr", sync_errors, 1);

        // Counter saturation.
        for (int i = 0; i < 260; i++) send_byte(8'h05, 1, 1, 0);
        chk("serr_sat", sync_errors, 8'hFF);
        for (int i = 0; i < 262; i++) begin
            send_byte(8'h81, 1, 1, 0);
            send_byte(8'h02, 1, 1, 0);
        end
        chk("drop_sat", overflow_drops, 8'hFF);
        idle(6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
